// File: rtl/tree_deserializer.sv
// Serial-to-parallel receiver: hunts for SYNC_WORD to recover word alignment,
// then emits MSB-first payload words with a one-cycle valid strobe.
module tree_deserializer #(
  parameter int                 WIDTH     = 8,
  parameter int                 LOGWIDTH  = 3,
  parameter logic [WIDTH-1:0]   SYNC_WORD = 8'hBC,
  parameter int                 LOCK_CNT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_i,
  input  logic             relock_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             locked_o,
  output logic             sync_err_o
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t              state_q;
  logic                data_q;
  logic [WIDTH-1:0]    sr_q, sr_d;
  logic [LOGWIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]          match_cnt_q;
  logic [WIDTH-1:0]    data_o_q;
  logic                valid_q, locked_q, sync_err_q;
  logic                boundary, sync_hit, lock_reached;

  always_comb begin
    sr_d         = {sr_q[WIDTH-2:0], data_q};
    sync_hit     = (sr_d == SYNC_WORD);
    boundary     = (cnt_q == LOGWIDTH'(WIDTH - 1));
    cnt_d        = boundary ? '0 : cnt_q + 1'b1;
    lock_reached = (({1'b0, match_cnt_q} + 5'd1) == 5'(LOCK_CNT));
  end

  // locked_o is updated on the same edge that enters or leaves LOCKED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HUNT;
      data_q      <= 1'b0;
      sr_q        <= '0;
      cnt_q       <= '0;
      match_cnt_q <= '0;
      data_o_q    <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      data_q     <= data_i;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      valid_q    <= 1'b0;
      sync_err_q <= 1'b0;
      if (relock_i) begin
        state_q     <= HUNT;
        match_cnt_q <= '0;
        locked_q    <= 1'b0;
      end else begin
        case (state_q)
          HUNT: begin
            if (sync_hit) begin
              cnt_q       <= '0;
              match_cnt_q <= 4'd1;
              if (LOCK_CNT == 1) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                state_q  <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (boundary) begin
              if (sync_hit) begin
                match_cnt_q <= match_cnt_q + 4'd1;
                if (lock_reached) begin
                  state_q  <= LOCKED;
                  locked_q <= 1'b1;
                end
              end else begin
                state_q     <= HUNT;
                match_cnt_q <= '0;
                sync_err_q  <= 1'b1;
              end
            end
          end
          LOCKED: begin
            // Sync words double as idle fill and are never delivered.
            if (boundary && !sync_hit) begin
              data_o_q <= sr_d;
              valid_q  <= 1'b1;
            end
          end
          default: begin
            state_q     <= HUNT;
            match_cnt_q <= '0;
            locked_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_o     = data_o_q;
  assign valid_o    = valid_q;
  assign locked_o   = locked_q;
  assign sync_err_o = sync_err_q;

endmodule

// File: tb/tb_tree_deserializer.sv
// Directed bench for tree_deserializer: lock acquisition, idle drop, sync
// failure, relock at a new bit offset, async reset, and a serializer-style stream.
module tb_tree_deserializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_i;
  logic       relock_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       locked_o;
  logic       sync_err_o;

  int checks   = 0;
  int failures = 0;

  int         cyc = 0;
  logic [7:0] vq_data[$];
  int         vq_cyc[$];
  int         serr_cnt = 0;
  int         locked_mon = 0;
  int         lk_snap;

  always #5 clk = ~clk;

  tree_deserializer #(
    .WIDTH(8), .LOGWIDTH(3), .SYNC_WORD(8'hBC), .LOCK_CNT(4)
  ) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .relock_i(relock_i),
    .data_o(data_o), .valid_o(valid_o), .locked_o(locked_o), .sync_err_o(sync_err_o)
  );

  // Records every strobe a little after each rising edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (valid_o) begin
      vq_data.push_back(data_o);
      vq_cyc.push_back(cyc);
    end
    if (sync_err_o) serr_cnt++;
    if (locked_o) locked_mon++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives bits hi..lo of w, one per cycle, changing data_i on falling edges.
  task automatic send_bits(input logic [7:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      @(negedge clk);
      data_i = w[i];
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    send_bits(w, 7, 0);
  endtask

  initial begin
    reset = 1'b1; data_i = 1'b0; relock_i = 1'b0;
    #1;
    chk("rst_data", 32'(data_o), 32'h00);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_locked", 32'(locked_o), 32'h0);
    chk("rst_serr", 32'(sync_err_o), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Acquire lock: 3 stray bits, 4 aligned sync words, then payload 0x5A.
    send_bits(8'h05, 2, 0);
    repeat (4) send_word(8'hBC);
    send_bits(8'h5A, 7, 7);
    chk("lock_early", 32'(locked_o), 32'h0);
    send_bits(8'h5A, 6, 6);
    chk("lock_rise", 32'(locked_o), 32'h1);
    send_bits(8'h5A, 5, 0);
    chk("no_valid_pre", 32'(vq_data.size()), 32'd0);
    send_bits(8'h01, 7, 7);
    chk("lat_edge1_valid", 32'(valid_o), 32'h0);
    send_bits(8'h01, 6, 6);
    chk("lat_edge2_valid", 32'(valid_o), 32'h1);
    chk("lat_edge2_data", 32'(data_o), 32'h5A);
    send_bits(8'h01, 5, 5);
    chk("strobe_one_cycle", 32'(valid_o), 32'h0);
    chk("data_hold", 32'(data_o), 32'h5A);

    // Payload, idle, payload back-to-back.
    send_bits(8'h01, 4, 0);
    send_word(8'hBC);
    send_word(8'hFF);
    send_word(8'hBC);
    chk("q_count_3", 32'(vq_data.size()), 32'd3);
    chk("q1_data", 32'(vq_data[1]), 32'h01);
    chk("q2_data", 32'(vq_data[2]), 32'hFF);
    chk("q_gap_idle", 32'(vq_cyc[2] - vq_cyc[1]), 32'd16);
    chk("still_locked", 32'(locked_o), 32'h1);

    // Relock, then re-acquire at a 2-bit offset.
    send_word(8'h11);
    send_word(8'h11);
    send_word(8'hBC);
    send_bits(8'h00, 7, 7);
    relock_i = 1'b1;
    send_bits(8'h00, 6, 6);
    relock_i = 1'b0;
    chk("relock_drop", 32'(locked_o), 32'h0);
    chk("q_count_5", 32'(vq_data.size()), 32'd5);
    chk("q4_data", 32'(vq_data[4]), 32'h11);
    repeat (4) send_word(8'hBC);
    send_bits(8'h66, 7, 6);
    chk("relock_rise", 32'(locked_o), 32'h1);
    chk("relock_no_valid", 32'(vq_data.size()), 32'd5);
    send_bits(8'h66, 5, 0);
    send_word(8'hBC);
    chk("q_count_6", 32'(vq_data.size()), 32'd6);
    chk("q5_data", 32'(vq_data[5]), 32'h66);

    // Asynchronous reset mid-word while locked.
    send_bits(8'h66, 7, 4);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_data", 32'(data_o), 32'h00);
    chk("arst_locked", 32'(locked_o), 32'h0);
    chk("arst_valid", 32'(valid_o), 32'h0);
    chk("arst_serr", 32'(sync_err_o), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lk_snap = locked_mon;

    // Two sync words then a bad boundary: one sync error, no lock.
    send_word(8'hBC);
    send_word(8'hBC);
    send_word(8'h3C);
    send_bits(8'h00, 7, 7);
    chk("serr_edge1", 32'(sync_err_o), 32'h0);
    send_bits(8'h00, 6, 6);
    chk("serr_edge2", 32'(sync_err_o), 32'h1);
    send_bits(8'h00, 5, 5);
    chk("serr_pulse_end", 32'(sync_err_o), 32'h0);
    send_bits(8'h00, 4, 0);
    chk("serr_total", 32'(serr_cnt), 32'd1);
    chk("serr_never_locked", 32'(locked_mon - lk_snap), 32'd0);
    chk("post_rst_no_valid", 32'(vq_data.size()), 32'd6);

    // Serializer-style loopback stream: 4 sync words, 0xA5, 0x3C.
    repeat (4) send_word(8'hBC);
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hBC);
    chk("loop_count", 32'(vq_data.size()), 32'd8);
    chk("loop_first", 32'(vq_data[6]), 32'hA5);
    chk("loop_second", 32'(vq_data[7]), 32'h3C);
    chk("loop_gap", 32'(vq_cyc[7] - vq_cyc[6]), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
